// File: rtl/conv_pool_writer.sv
// Convolution output stage: streaming 2x2/stride-2 max-pool, shift + ReLU/saturate
// activation, and two-results-per-word packing into the output SRAM.
module conv_pool_writer #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int ADDRW = 12,
    parameter int DATAW = 16,
    parameter int MAX_M = 64
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             frame_start,
    input  logic [7:0]       frame_m,
    input  logic [ADDRW-1:0] frame_base_addr,
    input  logic             act_mode,
    input  logic [2:0]       act_shift,
    input  logic             conv_valid,
    output logic             conv_ready,
    input  logic [ACC_W-1:0] conv_data,
    output logic             output_sram_write_enable,
    output logic [ADDRW-1:0] output_sram_write_addresss,
    output logic [DATAW-1:0] output_sram_write_data,
    output logic             frame_done,
    output logic             frame_error
);

    localparam int LB_DEPTH = MAX_M / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);
    localparam logic [7:0] MAX_M8 = 8'(MAX_M);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state, state_nxt;

    logic [7:0]       m_last;
    logic [7:0]       row;
    logic [7:0]       col;
    logic             mode_q;
    logic [2:0]       shift_q;
    logic [ADDRW-1:0] addr_q;
    logic             slot_full;
    logic [OUT_W-1:0] held_q;

    logic signed [ACC_W-1:0] h_q;
    logic signed [ACC_W-1:0] line_buf [LB_DEPTH];

    logic                    cfg_ok;
    logic                    xfer;
    logic                    last_p0;
    logic                    pool_vld_p0;
    logic [LB_AW-1:0]        lb_idx;
    logic signed [ACC_W-1:0] hm_p0;
    logic signed [ACC_W-1:0] pool_p0;
    logic signed [ACC_W-1:0] scaled_p0;
    logic [OUT_W-1:0]        act_p0;

    function automatic logic signed [ACC_W-1:0] smax(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Clamp to the OUT_W signed range; ReLU additionally floors at zero.
    function automatic logic [OUT_W-1:0] activate(
        input logic signed [ACC_W-1:0] s,
        input logic                    relu
    );
        logic [OUT_W-1:0] r;
        if (s > SAT_HI)
            r = SAT_HI[OUT_W-1:0];
        else if (relu && s[ACC_W-1])
            r = '0;
        else if (s < SAT_LO)
            r = SAT_LO[OUT_W-1:0];
        else
            r = s[OUT_W-1:0];
        return r;
    endfunction

    assign cfg_ok     = (frame_m != 8'd0) && !frame_m[0] && (frame_m <= MAX_M8);
    assign conv_ready = (state == RUN);
    assign xfer       = conv_valid && conv_ready;
    assign lb_idx     = col[LB_AW:1];

    // Stage p0: pooling and activation on the accepted sample
    assign hm_p0       = smax(h_q, conv_data);
    assign pool_p0     = smax(hm_p0, line_buf[lb_idx]);
    assign pool_vld_p0 = xfer && col[0] && row[0];
    assign last_p0     = xfer && (col == m_last) && (row == m_last);
    assign scaled_p0   = pool_p0 >>> shift_q;
    assign act_p0      = activate(scaled_p0, !mode_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start && cfg_ok) state_nxt = RUN;
            RUN:     if (last_p0) state_nxt = slot_full ? DONE : FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered SRAM write port and control
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                      <= IDLE;
            m_last                     <= '0;
            row                        <= '0;
            col                        <= '0;
            mode_q                     <= 1'b0;
            shift_q                    <= '0;
            addr_q                     <= '0;
            slot_full                  <= 1'b0;
            output_sram_write_enable   <= 1'b0;
            output_sram_write_addresss <= '0;
            output_sram_write_data     <= '0;
            frame_done                 <= 1'b0;
            frame_error                <= 1'b0;
        end else begin
            state                    <= state_nxt;
            output_sram_write_enable <= 1'b0;
            frame_done               <= (state == DONE);
            frame_error              <= (state == IDLE) && frame_start && !cfg_ok;
            case (state)
                IDLE: begin
                    if (frame_start && cfg_ok) begin
                        m_last    <= frame_m - 8'd1;
                        mode_q    <= act_mode;
                        shift_q   <= act_shift;
                        addr_q    <= frame_base_addr;
                        row       <= '0;
                        col       <= '0;
                        slot_full <= 1'b0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (col == m_last) begin
                            col <= '0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                        if (pool_vld_p0) begin
                            slot_full <= !slot_full;
                            if (slot_full) begin
                                output_sram_write_enable   <= 1'b1;
                                output_sram_write_addresss <= addr_q;
                                output_sram_write_data     <= {act_p0, held_q};
                                addr_q                     <= addr_q + 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    output_sram_write_enable   <= 1'b1;
                    output_sram_write_addresss <= addr_q;
                    output_sram_write_data     <= {{OUT_W{1'b0}}, held_q};
                    addr_q                     <= addr_q + 1'b1;
                    slot_full                  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath storage carries no reset; slot_full and the counters qualify it
    always_ff @(posedge clk) begin
        if (xfer && !col[0])
            h_q <= conv_data;
        if (xfer && col[0] && !row[0])
            line_buf[lb_idx] <= hm_p0;
        if (pool_vld_p0 && !slot_full)
            held_q <= act_p0;
    end

endmodule

// File: tb/tb_conv_pool_writer.sv
// Randomised + directed bench for conv_pool_writer against a frame-level
// pooling/activation/packing reference model.
module tb_conv_pool_writer;

    localparam int ACC_W = 20;
    localparam int OUT_W = 8;
    localparam int ADDRW = 12;
    localparam int DATAW = 16;
    localparam int MAX_M = 64;

    logic             clk = 1'b0;
    logic             reset_b = 1'b0;
    logic             frame_start = 1'b0;
    logic [7:0]       frame_m = '0;
    logic [ADDRW-1:0] frame_base_addr = '0;
    logic             act_mode = 1'b0;
    logic [2:0]       act_shift = '0;
    logic             conv_valid = 1'b0;
    logic             conv_ready;
    logic [ACC_W-1:0] conv_data = '0;
    logic             we;
    logic [ADDRW-1:0] waddr;
    logic [DATAW-1:0] wdata;
    logic             frame_done;
    logic             frame_error;

    conv_pool_writer #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDRW(ADDRW), .DATAW(DATAW), .MAX_M(MAX_M)
    ) dut (
        .clk                        (clk),
        .reset_b                    (reset_b),
        .frame_start                (frame_start),
        .frame_m                    (frame_m),
        .frame_base_addr            (frame_base_addr),
        .act_mode                   (act_mode),
        .act_shift                  (act_shift),
        .conv_valid                 (conv_valid),
        .conv_ready                 (conv_ready),
        .conv_data                  (conv_data),
        .output_sram_write_enable   (we),
        .output_sram_write_addresss (waddr),
        .output_sram_write_data     (wdata),
        .frame_done                 (frame_done),
        .frame_error                (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cyc[$];
    int err_cnt = 0;

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(int'(waddr));
            wr_data.push_back(int'(wdata));
            wr_cyc.push_back(cyc);
        end
        if (frame_done) done_cyc.push_back(cyc);
        if (frame_error) err_cnt++;
    end

    int samp[$];
    int exp_w[$];
    int last_edge = 0;

    // Reference: pool each 2x2 block of the frame, shift, clamp, pack pairs low-first.
    task automatic model(input int m, input int mode, input int shift);
        int bytes[$];
        int p, s, lo;
        exp_w.delete();
        lo = (mode != 0) ? -128 : 0;
        for (int pr = 0; pr < m / 2; pr++) begin
            for (int pc = 0; pc < m / 2; pc++) begin
                p = samp[(2 * pr) * m + 2 * pc];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (samp[(2 * pr + dr) * m + 2 * pc + dc] > p)
                            p = samp[(2 * pr + dr) * m + 2 * pc + dc];
                s = p >>> shift;
                if (s > 127) s = 127;
                if (s < lo) s = lo;
                bytes.push_back(s & 255);
            end
        end
        for (int k = 0; k < bytes.size(); k += 2)
            exp_w.push_back((k + 1 < bytes.size()) ? ((bytes[k + 1] << 8) | bytes[k]) : bytes[k]);
    endtask

    task automatic fill_rand(input int m);
        samp.delete();
        for (int i = 0; i < m * m; i++) begin
            if ($urandom_range(0, 7) == 0)
                samp.push_back(int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1)));
            else
                samp.push_back(int'($urandom_range(0, 600)) - 300);
        end
    endtask

    task automatic fill_const(input int m, input int v);
        samp.delete();
        for (int i = 0; i < m * m; i++) samp.push_back(v);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic start_frame(input string tag, input int m, input int base, input int mode, input int shift);
        clear_mon();
        @(negedge clk);
        frame_start     = 1'b1;
        frame_m         = 8'(m);
        frame_base_addr = ADDRW'(base);
        act_mode        = 1'(mode);
        act_shift       = 3'(shift);
        @(negedge clk);
        frame_start     = 1'b0;
        frame_m         = 8'hFF;
        frame_base_addr = ADDRW'($urandom);
        act_mode        = ~act_mode;
        act_shift       = 3'($urandom);
        check({tag, "_ready_rise"}, 32'(conv_ready), 32'd1);
    endtask

    // stall: 0 = always valid, 1 = every other cycle, 2 = random
    task automatic feed(input string tag, input int n, input int stall, input bit glitch);
        int idx = 0;
        int budget = 0;
        bit v;
        while (idx < n && budget < 20000) begin
            budget++;
            v = (stall == 0) ? 1'b1 : (stall == 1) ? (budget % 2 == 0) : ($urandom_range(0, 2) != 0);
            conv_valid  = v;
            conv_data   = samp[idx][ACC_W-1:0];
            frame_start = glitch && (idx == n / 2);
            if (frame_start) frame_m = 8'd2;
            if (v && conv_ready) begin
                idx++;
                last_edge = cyc + 1;
            end
            @(negedge clk);
        end
        conv_valid  = 1'b0;
        frame_start = 1'b0;
        check({tag, "_fed"}, 32'(idx), 32'(n));
    endtask

    task automatic finish_check(input string tag, input int m, input int base);
        int wait_n = 0;
        int odd;
        int n;
        odd = (m / 2) % 2;
        while (done_cyc.size() == 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        check({tag, "_done_cnt"}, 32'(done_cyc.size()), 32'd1);
        check({tag, "_nwords"}, 32'(wr_addr.size()), 32'(exp_w.size()));
        n = (wr_addr.size() < exp_w.size()) ? wr_addr.size() : exp_w.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[k]), 32'((base + k) % (1 << ADDRW)));
            check($sformatf("%s_data%0d", tag, k), 32'(wr_data[k]), 32'(exp_w[k]));
        end
        if (wr_cyc.size() > 0) begin
            check({tag, "_last_wr_lat"}, 32'(wr_cyc[wr_cyc.size() - 1] - last_edge), 32'(odd));
            if (done_cyc.size() > 0)
                check({tag, "_done_lat"}, 32'(done_cyc[0] - wr_cyc[wr_cyc.size() - 1]), 32'd1);
        end
        check({tag, "_no_err"}, 32'(err_cnt), 32'd0);
        check({tag, "_ready_low"}, 32'(conv_ready), 32'd0);
    endtask

    task automatic run(input string tag, input int m, input int base, input int mode,
                       input int shift, input int stall, input bit glitch);
        model(m, mode, shift);
        start_frame(tag, m, base, mode, shift);
        feed(tag, m * m, stall, glitch);
        finish_check(tag, m, base);
    endtask

    task automatic reject(input string tag, input int m);
        clear_mon();
        @(negedge clk);
        frame_start = 1'b1;
        frame_m     = 8'(m);
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, "_err_pulse"}, 32'(frame_error), 32'd1);
        check({tag, "_ready0"}, 32'(conv_ready), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_err_once"}, 32'(err_cnt), 32'd1);
        check({tag, "_ready1"}, 32'(conv_ready), 32'd0);
        check({tag, "_no_wr"}, 32'(wr_addr.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(conv_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(waddr), 32'd0);
        check("rst_data", 32'(wdata), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_error), 32'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp 0..15, M=4
        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(i);
        run("ramp", 4, 'h100, 0, 0, 0, 1'b0);
        if (wr_data.size() >= 2) begin
            check("ramp_w0", 32'(wr_data[0]), 32'h0705);
            check("ramp_w1", 32'(wr_data[1]), 32'h0F0D);
        end

        // Single negative pooled value, flushed
        samp.delete();
        samp.push_back(-3); samp.push_back(-9); samp.push_back(-1); samp.push_back(-20);
        run("neg_sat", 2, 'h020, 1, 0, 0, 1'b0);
        if (wr_data.size() >= 1) check("neg_sat_w", 32'(wr_data[0]), 32'h00FF);
        run("neg_relu", 2, 'h020, 0, 0, 0, 1'b0);
        if (wr_data.size() >= 1) check("neg_relu_w", 32'(wr_data[0]), 32'h0000);

        // Saturation and shift
        fill_const(6, 1000);
        run("sat6", 6, 'h040, 0, 0, 0, 1'b0);
        if (wr_data.size() == 5) check("sat6_last", 32'(wr_data[4]), 32'h007F);
        fill_const(4, 80);
        run("shift3", 4, 'h050, 0, 3, 0, 1'b0);
        if (wr_data.size() >= 1) check("shift3_w0", 32'(wr_data[0]), 32'h0A0A);

        // Stalled input plus frame_start outside IDLE
        fill_rand(4);
        run("stall_ref", 4, 'h060, 1, 1, 0, 1'b0);
        run("stall_alt", 4, 'h060, 1, 1, 1, 1'b1);

        // Rejected configurations
        reject("rej5", 5);
        reject("rej0", 0);
        reject("rej66", 66);

        // Address wrap
        fill_rand(4);
        run("wrap", 4, 'hFFF, 1, 0, 0, 1'b0);
        if (wr_addr.size() >= 2) check("wrap_a1", 32'(wr_addr[1]), 32'h000);

        // Reset mid-frame after 7 samples
        fill_rand(4);
        start_frame("midrst", 4, 'h123, 1, 0);
        feed("midrst", 7, 0, 1'b0);
        reset_b = 1'b0;
        #1;
        check("midrst_ready", 32'(conv_ready), 32'd0);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_addr", 32'(waddr), 32'd0);
        check("midrst_data", 32'(wdata), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        check("midrst_err", 32'(frame_error), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_done", 32'(done_cyc.size()), 32'd0);
        check("midrst_no_wr", 32'(wr_addr.size()), 32'd0);
        fill_rand(8);
        run("after_rst", 8, 'h200, 0, 2, 2, 1'b0);

        // Largest frame, then random frames
        fill_rand(64);
        run("max64", 64, 'h300, 1, 4, 0, 1'b0);
        for (int t = 0; t < 6; t++) begin
            int m;
            m = 2 * int'($urandom_range(1, 16));
            fill_rand(m);
            run($sformatf("rnd%0d", t), m, int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 2)), 1'(t % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
